// File: rtl/wb_commit_buffer.sv
// Write-back commit FIFO: in-order retire to the regfile, exception/ERET commit to CP0, decode forwarding.
// Optional feature macro WB_FWD_EN: when defined, forwarded data is driven; otherwise only fwd_busy is driven.
module wb_commit_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [PC_W-1:0]   ms_pc,
  input  logic              ms_gr_we,
  input  logic [ADDR_W-1:0] ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ms_ex,
  input  logic [4:0]        ms_ex_code,
  input  logic              ms_bd,
  input  logic              ms_eret,
  input  logic [PC_W-1:0]   ms_badvaddr,
  input  logic              rf_wr_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ex_valid,
  output logic [4:0]        ex_code,
  output logic              ex_bd,
  output logic [PC_W-1:0]   ex_pc,
  output logic [PC_W-1:0]   ex_badvaddr,
  output logic              eret_valid,
  output logic              ws_flush,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_busy,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic              gr_we_q  [DEPTH];
  logic [ADDR_W-1:0] dest_q   [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic              ex_q     [DEPTH];
  logic [4:0]        code_q   [DEPTH];
  logic              bd_q     [DEPTH];
  logic              eret_q   [DEPTH];
  logic [PC_W-1:0]   bva_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head;
  logic             head_vld, head_flush, retire, enq;
  logic [DEPTH-1:0] match_age;

  // Commit outputs are masked during reset so a reset cycle never retires or signals CP0.
  assign head       = rd_ptr_q;
  assign head_vld   = ~reset & (count_q != '0);
  assign head_flush = head_vld & (ex_q[head] | eret_q[head]);
  assign retire     = head_vld & (ex_q[head] | eret_q[head] | ~gr_we_q[head] | rf_wr_ready);
  assign ws_flush   = head_flush;
  assign ws_allowin = ~reset & (count_q != CNT_W'(DEPTH)) & ~head_flush;
  assign enq        = ms_to_ws_valid & ws_allowin;

  assign rf_we       = head_vld & gr_we_q[head] & ~ex_q[head] & ~eret_q[head] & rf_wr_ready;
  assign rf_waddr    = head_vld ? dest_q[head] : '0;
  assign rf_wdata    = head_vld ? result_q[head] : '0;
  assign ex_valid    = head_vld & ex_q[head];
  assign eret_valid  = head_vld & ~ex_q[head] & eret_q[head];
  assign ex_code     = ex_valid ? code_q[head] : '0;
  assign ex_bd       = ex_valid & bd_q[head];
  assign ex_pc       = ex_valid ? pc_q[head] : '0;
  assign ex_badvaddr = ex_valid ? bva_q[head] : '0;

  assign debug_wb_pc       = retire ? pc_q[head] : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (head_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (retire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, retire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[wr_ptr_q]     <= ms_pc;
      gr_we_q[wr_ptr_q]  <= ms_gr_we;
      dest_q[wr_ptr_q]   <= ms_dest;
      result_q[wr_ptr_q] <= ms_result;
      ex_q[wr_ptr_q]     <= ms_ex;
      code_q[wr_ptr_q]   <= ms_ex_code;
      bd_q[wr_ptr_q]     <= ms_bd;
      eret_q[wr_ptr_q]   <= ms_eret;
      bva_q[wr_ptr_q]    <= ms_badvaddr;
    end
  end

  // match_age[a] refers to the entry a slots behind the head, so higher a is younger.
  always_comb begin
    match_age = '0;
    for (int a = 0; a < DEPTH; a++) begin
      logic [PTR_W-1:0] fidx;
      fidx = rd_ptr_q + PTR_W'(a);
      match_age[a] = ~reset & (fwd_raddr != '0) & (CNT_W'(a) < count_q) &
                     gr_we_q[fidx] & ~ex_q[fidx] & (dest_q[fidx] == fwd_raddr);
    end
  end

  assign fwd_busy = |match_age;

`ifdef WB_FWD_EN
  always_comb begin
    fwd_data = '0;
    for (int a = 0; a < DEPTH; a++)
      if (match_age[a]) fwd_data = result_q[rd_ptr_q + PTR_W'(a)];
  end
  assign fwd_hit = fwd_busy;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule
